// File: rtl/step_dir_shaper.sv
// -----------------------------------------------------------------------------
// step_dir_shaper
//
// Purpose:
//   Output stage between the tracking step-pulse generator and an external
//   stepper driver. Raw one-clock step requests are turned into STEP/DIR/EN
//   waveforms that respect the driver's timing limits:
//     - DIR is stable for DIR_SETUP clocks before a STEP rising edge.
//     - STEP is high for exactly PULSE_W clocks.
//     - STEP then stays low for exactly LOW_W clocks. DIR is only changed in
//       IDLE, so the DIR hold time after a pulse is at least LOW_W.
//   Requests toward an active end switch or beyond the soft travel window
//   are blocked. A signed absolute position count is kept.
//
// Ports:
//   clk            in   system clock (50 MHz)
//   rst            in   synchronous reset, active-high
//   drv_step       in   step request, rising edge = one step
//   drv_dir        in   requested direction (1 = +, 0 = -)
//   drv_enable_SM  in   motor enable from the tracking block
//   limit_lo       in   lower end switch, active-high, synchronised
//   limit_hi       in   upper end switch, active-high, synchronised
//   pos_clear      in   strobe: position <= 0, limit_hit <= 0
//   step_out       out  STEP to driver (registered)
//   dir_out        out  DIR to driver (registered)
//   en_out         out  EN to driver, drv_enable_SM delayed one clock
//   position       out  signed step count
//   busy           out  high whenever the FSM is not in IDLE
//   step_dropped   out  one-clock pulse, request rejected (busy/disabled)
//   limit_hit      out  sticky, a request was blocked by a limit
// -----------------------------------------------------------------------------
module step_dir_shaper #(
  parameter int                      DIR_SETUP = 25,
  parameter int                      PULSE_W   = 50,
  parameter int                      LOW_W     = 50,
  parameter int                      POS_W     = 32,
  parameter logic signed [POS_W-1:0] POS_MAX   = 32'sd100000,
  parameter logic signed [POS_W-1:0] POS_MIN   = -32'sd100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    limit_lo,
  input  logic                    limit_hi,
  input  logic                    pos_clear,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    en_out,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    step_dropped,
  output logic                    limit_hit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  // One down-counter serves every timed state; it only ever holds N-1.
  localparam int T_MAX_A = (PULSE_W > LOW_W) ? PULSE_W : LOW_W;
  localparam int T_MAX   = (T_MAX_A > DIR_SETUP) ? T_MAX_A : DIR_SETUP;
  localparam int TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(DIR_SETUP - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] LOW_LD   = TMR_W'(LOW_W - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

  state_t                    state_r;
  logic [TMR_W-1:0]          timer_r;
  logic                      step_out_r;
  logic                      dir_out_r;
  logic                      en_out_r;
  logic                      busy_r;
  logic                      drv_step_d_r;
  logic                      step_dropped_r;
  logic                      limit_hit_r;
  logic signed [POS_W-1:0]   position_r;

  logic                      req_s;
  logic                      timer_done_s;
  logic                      blocked_s;
  logic                      idle_req_s;
  logic                      accept_s;
  logic                      block_s;
  logic                      drop_s;
  logic                      enter_pulse_s;

  // Request decode, limit check and the events shared by FSM and counters.
  always_comb begin
    req_s        = drv_step & ~drv_step_d_r;
    timer_done_s = (timer_r == TMR_ZERO);
    if (drv_dir) begin
      blocked_s = limit_hi | (position_r >= POS_MAX);
    end else begin
      blocked_s = limit_lo | (position_r <= POS_MIN);
    end
    idle_req_s = en_out_r & (state_r == ST_IDLE) & req_s;
    block_s    = idle_req_s & blocked_s;
    accept_s   = idle_req_s & ~blocked_s;
    // A request is dropped whenever it cannot start a step; nothing is queued.
    drop_s     = req_s & (busy_r | ~en_out_r);
    // The step is counted on the clock that STEP goes high.
    enter_pulse_s = en_out_r &
                    ((accept_s & (drv_dir == dir_out_r)) |
                     ((state_r == ST_SETUP) & timer_done_s));
  end

  // Step/dir sequencer with registered STEP, DIR and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= TMR_ZERO;
      step_out_r <= 1'b0;
      dir_out_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else if (!en_out_r) begin
      // Enable loss aborts any phase; DIR is left where it was.
      state_r    <= ST_IDLE;
      timer_r    <= TMR_ZERO;
      step_out_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            busy_r <= 1'b1;
            if (drv_dir == dir_out_r) begin
              state_r    <= ST_PULSE;
              timer_r    <= PULSE_LD;
              step_out_r <= 1'b1;
            end else begin
              dir_out_r <= drv_dir;
              state_r   <= ST_SETUP;
              timer_r   <= SETUP_LD;
            end
          end
        end
        ST_SETUP: begin
          if (timer_done_s) begin
            state_r    <= ST_PULSE;
            timer_r    <= PULSE_LD;
            step_out_r <= 1'b1;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        ST_PULSE: begin
          // Limits are not looked at here: a pulse in flight always completes.
          if (timer_done_s) begin
            state_r    <= ST_LOW;
            timer_r    <= LOW_LD;
            step_out_r <= 1'b0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        ST_LOW: begin
          if (timer_done_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          timer_r    <= TMR_ZERO;
          step_out_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Input edge-detect register and the one-clock enable delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      drv_step_d_r <= 1'b0;
      en_out_r     <= 1'b0;
    end else begin
      drv_step_d_r <= drv_step;
      en_out_r     <= drv_enable_SM;
    end
  end

  // Rejection strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_dropped_r <= 1'b0;
    end else begin
      step_dropped_r <= drop_s;
    end
  end

  // Sticky limit flag; a block in the same clock as pos_clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_hit_r <= 1'b0;
    end else if (block_s) begin
      limit_hit_r <= 1'b1;
    end else if (pos_clear) begin
      limit_hit_r <= 1'b0;
    end
  end

  // Position counter; pos_clear overrides a same-clock step.
  always_ff @(posedge clk) begin
    if (rst) begin
      position_r <= POS_ZERO;
    end else if (pos_clear) begin
      position_r <= POS_ZERO;
    end else if (enter_pulse_s) begin
      if (dir_out_r) begin
        position_r <= position_r + POS_ONE;
      end else begin
        position_r <= position_r - POS_ONE;
      end
    end
  end

  assign step_out     = step_out_r;
  assign dir_out      = dir_out_r;
  assign en_out       = en_out_r;
  assign position     = position_r;
  assign busy         = busy_r;
  assign step_dropped = step_dropped_r;
  assign limit_hit    = limit_hit_r;

endmodule

// File: tb/tb_step_dir_shaper.sv
// -----------------------------------------------------------------------------
// tb_step_dir_shaper
//
// Directed bench for step_dir_shaper. A timestamp model predicts every output
// on every clock: an accepted step is recorded as the clock STEP rises, the
// clock it falls and the clock busy ends. A compare process checks all
// outputs against that model on each falling edge. Directed literal checks
// pin the latencies, widths and positions of each scenario.
// -----------------------------------------------------------------------------
module tb_step_dir_shaper;

  localparam int                      DIR_SETUP = 25;
  localparam int                      PULSE_W   = 50;
  localparam int                      LOW_W     = 50;
  localparam int                      POS_W     = 32;
  localparam logic signed [POS_W-1:0] POS_MAX   = 32'sd3;
  localparam logic signed [POS_W-1:0] POS_MIN   = -32'sd3;

  logic                    clk           = 1'b0;
  logic                    rst           = 1'b1;
  logic                    drv_step      = 1'b0;
  logic                    drv_dir       = 1'b0;
  logic                    drv_enable_SM = 1'b0;
  logic                    limit_lo      = 1'b0;
  logic                    limit_hi      = 1'b0;
  logic                    pos_clear     = 1'b0;
  logic                    step_out;
  logic                    dir_out;
  logic                    en_out;
  logic signed [POS_W-1:0] position;
  logic                    busy;
  logic                    step_dropped;
  logic                    limit_hit;

  int errors = 0;
  int checks = 0;
  int rises  = 0;
  int n_edge = 0;
  bit chk_on = 1'b0;

  always #10 clk = ~clk;

  step_dir_shaper #(
    .DIR_SETUP (DIR_SETUP),
    .PULSE_W   (PULSE_W),
    .LOW_W     (LOW_W),
    .POS_W     (POS_W),
    .POS_MAX   (POS_MAX),
    .POS_MIN   (POS_MIN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .drv_step      (drv_step),
    .drv_dir       (drv_dir),
    .drv_enable_SM (drv_enable_SM),
    .limit_lo      (limit_lo),
    .limit_hi      (limit_hi),
    .pos_clear     (pos_clear),
    .step_out      (step_out),
    .dir_out       (dir_out),
    .en_out        (en_out),
    .position      (position),
    .busy          (busy),
    .step_dropped  (step_dropped),
    .limit_hit     (limit_hit)
  );

  always @(posedge step_out) rises = rises + 1;

  task automatic cmp(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timestamp model ----------------
  bit m_en, m_prev, m_dir, m_lhit, m_drop, m_pend;
  int m_pos, m_rise, m_fall, m_bend, m_delta;

  always @(posedge clk) begin : model_p
    bit req_v, busy_v, blk_v;
    n_edge = n_edge + 1;
    if (rst) begin
      m_en = 0; m_prev = 0; m_dir = 0; m_lhit = 0; m_drop = 0; m_pend = 0;
      m_pos = 0; m_rise = 0; m_fall = 0; m_bend = 0; m_delta = 0;
    end else begin
      req_v  = drv_step && !m_prev;
      busy_v = (n_edge - 1) < m_bend;
      blk_v  = 0;
      m_drop = req_v && (busy_v || !m_en);
      if (!m_en) begin
        if (m_rise >= n_edge) m_pend = 0;
        if (m_fall > n_edge)  m_fall = n_edge;
        if (m_bend > n_edge)  m_bend = n_edge;
      end else if (req_v && !busy_v) begin
        blk_v = drv_dir ? (limit_hi || m_pos >= POS_MAX) : (limit_lo || m_pos <= POS_MIN);
        if (blk_v) begin
          m_lhit = 1;
        end else begin
          m_rise  = n_edge + ((drv_dir == m_dir) ? 0 : DIR_SETUP);
          m_fall  = m_rise + PULSE_W;
          m_bend  = m_fall + LOW_W;
          m_dir   = drv_dir;
          m_pend  = 1;
          m_delta = drv_dir ? 1 : -1;
        end
      end
      if (m_pend && n_edge == m_rise) begin
        m_pos  = m_pos + m_delta;
        m_pend = 0;
      end
      if (pos_clear) begin
        m_pos = 0;
        if (!blk_v) m_lhit = 0;
      end
      m_en   = drv_enable_SM;
      m_prev = drv_step;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_step_out", step_out, (n_edge >= m_rise && n_edge < m_fall));
      cmp("m_dir_out", dir_out, m_dir);
      cmp("m_en_out", en_out, m_en);
      cmp("m_position", position, m_pos);
      cmp("m_busy", busy, (n_edge < m_bend));
      cmp("m_step_dropped", step_dropped, m_drop);
      cmp("m_limit_hit", limit_hit, m_lhit);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_req(input logic d);
    drv_dir  = d;
    drv_step = 1'b1;
    @(negedge clk);
    drv_step = 1'b0;
  endtask

  task automatic run_idle(output int lat, output int hi, output int bz);
    lat = -1; hi = 0; bz = 0;
    while (busy && bz < 400) begin
      if (step_out) begin
        if (lat < 0) lat = bz;
        hi++;
      end
      bz++;
      @(negedge clk);
    end
    cmp("idle_reached", busy, 0);
  endtask

  task automatic wait_high(output int k);
    k = 0;
    while (!step_out && k < 100) begin
      @(negedge clk);
      k++;
    end
    cmp("step_high_reached", step_out, 1);
  endtask

  task automatic clear_pulse();
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, hi, bz, r0;
    @(posedge clk);
    chk_on = 1'b1;
    drv_enable_SM = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_position", position, 0);
    cmp("rst_en_out", en_out, 0);
    cmp("rst_step_out", step_out, 0);
    cmp("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp("en_out_up", en_out, 1);

    // First up-step from reset needs a DIR change (dir_out resets to 0).
    step_req(1'b1);
    run_idle(lat, hi, bz);
    cmp("a_lat", lat, 25);
    cmp("a_high", hi, 50);
    cmp("a_busy", bz, 125);
    cmp("a_pos", position, 1);

    // Test 1: same direction, STEP follows the request immediately.
    step_req(1'b1);
    run_idle(lat, hi, bz);
    cmp("t1_lat", lat, 0);
    cmp("t1_high", hi, 50);
    cmp("t1_busy", bz, 100);
    cmp("t1_pos", position, 2);

    // Test 2: direction change 1 -> 0.
    step_req(1'b0);
    cmp("t2_dir_out", dir_out, 0);
    run_idle(lat, hi, bz);
    cmp("t2_lat", lat, 25);
    cmp("t2_high", hi, 50);
    cmp("t2_pos", position, 1);

    // Test 3: second request 30 clocks after the first is dropped.
    r0 = rises;
    step_req(1'b1);
    repeat (29) @(negedge clk);
    step_req(1'b1);
    cmp("t3_dropped", step_dropped, 1);
    run_idle(lat, hi, bz);
    cmp("t3_pulses", rises - r0, 1);
    cmp("t3_pos", position, 2);

    // Test 4: hard upper limit blocks, opposite direction still allowed.
    limit_hi = 1'b1;
    r0 = rises;
    step_req(1'b1);
    cmp("t4_not_busy", busy, 0);
    cmp("t4_limit_hit", limit_hit, 1);
    cmp("t4_dir_kept", dir_out, 1);
    repeat (5) @(negedge clk);
    cmp("t4_no_pulse", rises - r0, 0);
    step_req(1'b0);
    run_idle(lat, hi, bz);
    cmp("t4_down_lat", lat, 25);
    cmp("t4_down_pos", position, 1);
    cmp("t4_hit_sticky", limit_hit, 1);
    limit_hi = 1'b0;
    clear_pulse();
    cmp("t4_clr_pos", position, 0);
    cmp("t4_clr_hit", limit_hit, 0);

    // Test 5: enable drops 10 clocks into the pulse.
    step_req(1'b1);
    wait_high(lat);
    cmp("t5_rise_lat", lat, 25);
    repeat (10) @(negedge clk);
    drv_enable_SM = 1'b0;
    @(negedge clk);
    cmp("t5_still_high", step_out, 1);
    @(negedge clk);
    cmp("t5_step_low", step_out, 0);
    cmp("t5_idle", busy, 0);
    cmp("t5_pos_kept", position, 1);
    step_req(1'b1);
    cmp("t5_drop_disabled", step_dropped, 1);
    drv_enable_SM = 1'b1;
    repeat (3) @(negedge clk);

    // Test 6: soft upper limit at 3, five up-steps 120 clocks apart.
    clear_pulse();
    r0 = rises;
    for (int i = 0; i < 5; i++) begin
      step_req(1'b1);
      repeat (119) @(negedge clk);
    end
    cmp("t6_pos", position, 3);
    cmp("t6_pulses", rises - r0, 3);
    cmp("t6_limit_hit", limit_hit, 1);

    // Reset in the middle of a pulse.
    step_req(1'b0);
    wait_high(lat);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("r_step_out", step_out, 0);
    cmp("r_dir_out", dir_out, 0);
    cmp("r_position", position, 0);
    cmp("r_busy", busy, 0);
    cmp("r_en_out", en_out, 0);
    cmp("r_limit_hit", limit_hit, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
